// File: rtl/regfile_mp.sv
// Multi-port register file: two combinational read ports, two write ports,
// optional write-to-read bypass, pending scoreboard and a registered debug read.
module regfile_mp #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic [AW-1:0] rna,
    input  logic [AW-1:0] rnb,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb,
    output logic          pa,
    output logic          pb,
    input  logic          we0,
    input  logic [AW-1:0] wn0,
    input  logic [DW-1:0] d0,
    input  logic          we1,
    input  logic [AW-1:0] wn1,
    input  logic [DW-1:0] d1,
    input  logic          iss_we,
    input  logic [AW-1:0] iss_wn,
    input  logic [AW-1:0] dbg_rn,
    output logic [DW-1:0] dbg_q
);

    localparam int NREG = 2 ** AW;

    logic [DW-1:0]   mem_r [NREG];
    logic [NREG-1:0] pend_r;

    logic wr0_ok_s;
    logic wr1_ok_s;

    assign wr0_ok_s = we0 && !(ZERO_R0 && (wn0 == '0));
    assign wr1_ok_s = we1 && !(ZERO_R0 && (wn1 == '0));

    // Array storage; port 1 is written last so it wins an address collision.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < NREG; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (wr0_ok_s) begin
                mem_r[wn0] <= d0;
            end
            if (wr1_ok_s) begin
                mem_r[wn1] <= d1;
            end
        end
    end

    // Pending scoreboard; a new issue overrides a completion to the same register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pend_r <= '0;
        end else begin
            if (we1) begin
                pend_r[wn1] <= 1'b0;
            end
            if (iss_we) begin
                pend_r[iss_wn] <= 1'b1;
            end
            if (ZERO_R0) begin
                pend_r[0] <= 1'b0;
            end
        end
    end

    // Read port A data with optional same-cycle forwarding.
    always_comb begin
        qa = mem_r[rna];
        if (ZERO_R0 && (rna == '0)) begin
            qa = '0;
        end else if (BYPASS && we1 && (wn1 == rna)) begin
            qa = d1;
        end else if (BYPASS && we0 && (wn0 == rna)) begin
            qa = d0;
        end else begin
            qa = mem_r[rna];
        end
    end

    // Read port B data with optional same-cycle forwarding.
    always_comb begin
        qb = mem_r[rnb];
        if (ZERO_R0 && (rnb == '0)) begin
            qb = '0;
        end else if (BYPASS && we1 && (wn1 == rnb)) begin
            qb = d1;
        end else if (BYPASS && we0 && (wn0 == rnb)) begin
            qb = d0;
        end else begin
            qb = mem_r[rnb];
        end
    end

    // Pending flags; a completing port-1 write hides the flag when forwarding.
    always_comb begin
        pa = pend_r[rna] && !(BYPASS && we1 && (wn1 == rna)) && !(ZERO_R0 && (rna == '0));
        pb = pend_r[rnb] && !(BYPASS && we1 && (wn1 == rnb)) && !(ZERO_R0 && (rnb == '0));
    end

    // Debug read sees array contents only, before this edge's writes.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            dbg_q <= '0;
        end else if (ZERO_R0 && (dbg_rn == '0)) begin
            dbg_q <= '0;
        end else begin
            dbg_q <= mem_r[dbg_rn];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a bypassing and a non-bypassing instance
// are driven with directed scenarios and random traffic, checked against a model.
module tb_regfile_mp;

    logic        clk;
    logic        clrn;
    logic [4:0]  rna, rnb, wn0, wn1, iss_wn, dbg_rn;
    logic [31:0] d0, d1;
    logic        we0, we1, iss_we;

    logic [31:0] qa_b, qb_b, dbg_b, qa_n, qb_n, dbg_n;
    logic        pa_b, pb_b, pa_n, pb_n;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_mem [32];
    bit          m_pend [32];
    logic [31:0] exp_dbg;

    regfile_mp #(.DW(32), .AW(5), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .clrn(clrn), .rna(rna), .rnb(rnb), .qa(qa_b), .qb(qb_b),
        .pa(pa_b), .pb(pb_b), .we0(we0), .wn0(wn0), .d0(d0), .we1(we1),
        .wn1(wn1), .d1(d1), .iss_we(iss_we), .iss_wn(iss_wn),
        .dbg_rn(dbg_rn), .dbg_q(dbg_b)
    );

    regfile_mp #(.DW(32), .AW(5), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .clrn(clrn), .rna(rna), .rnb(rnb), .qa(qa_n), .qb(qb_n),
        .pa(pa_n), .pb(pb_n), .we0(we0), .wn0(wn0), .d0(d0), .we1(we1),
        .wn1(wn1), .d1(d1), .iss_we(iss_we), .iss_wn(iss_wn),
        .dbg_rn(dbg_rn), .dbg_q(dbg_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_q(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && we1 && wn1 == a) return d1;
        if (byp && we0 && wn0 == a) return d0;
        return m_mem[a];
    endfunction

    function automatic logic [31:0] exp_p(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && we1 && wn1 == a) return 32'd0;
        return {31'd0, m_pend[a]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'd0;
            m_pend[i] = 1'b0;
        end
        exp_dbg = 32'd0;
    endtask

    // Single compare process: every falling edge, both instances vs. the model.
    always @(negedge clk) begin
        chk("qa_byp", qa_b, exp_q(rna, 1'b1));
        chk("qb_byp", qb_b, exp_q(rnb, 1'b1));
        chk("pa_byp", {31'd0, pa_b}, exp_p(rna, 1'b1));
        chk("pb_byp", {31'd0, pb_b}, exp_p(rnb, 1'b1));
        chk("dbg_byp", dbg_b, exp_dbg);
        chk("qa_nob", qa_n, exp_q(rna, 1'b0));
        chk("qb_nob", qb_n, exp_q(rnb, 1'b0));
        chk("pa_nob", {31'd0, pa_n}, exp_p(rna, 1'b0));
        chk("pb_nob", {31'd0, pb_n}, exp_p(rnb, 1'b0));
        chk("dbg_nob", dbg_n, exp_dbg);
    end

    // Advance one clock: the model absorbs the inputs sampled at the edge, strobes go idle.
    task automatic tick();
        @(posedge clk);
        if (clrn) begin
            exp_dbg = (dbg_rn == 5'd0) ? 32'd0 : m_mem[dbg_rn];
            if (we0 && wn0 != 5'd0) m_mem[wn0] = d0;
            if (we1 && wn1 != 5'd0) m_mem[wn1] = d1;
            if (we1) m_pend[wn1] = 1'b0;
            if (iss_we) m_pend[iss_wn] = 1'b1;
            m_pend[0] = 1'b0;
        end
        #1;
        we0 = 1'b0;
        we1 = 1'b0;
        iss_we = 1'b0;
    endtask

    initial begin
        clrn = 1'b0;
        rna = 5'd0; rnb = 5'd0; dbg_rn = 5'd0;
        we0 = 1'b0; wn0 = 5'd0; d0 = 32'd0;
        we1 = 1'b0; wn1 = 5'd0; d1 = 32'd0;
        iss_we = 1'b0; iss_wn = 5'd0;
        model_reset();

        tick();
        tick();
        clrn = 1'b1;

        // Sweep all addresses out of reset
        for (int i = 0; i < 32; i++) begin
            rna = 5'(i); rnb = 5'(31 - i); dbg_rn = 5'(i);
            tick();
        end
        @(negedge clk);
        chk("lit_reset_dbg", dbg_b, 32'd0);

        // Write/read independence
        we0 = 1'b1; wn0 = 5'd5; d0 = 32'h1234_5678;
        tick();
        we0 = 1'b1; wn0 = 5'd9; d0 = 32'hDEAD_BEEF;
        tick();
        rna = 5'd5; rnb = 5'd9;
        @(negedge clk);
        chk("lit_r5", qa_n, 32'h1234_5678);
        chk("lit_r9", qb_n, 32'hDEAD_BEEF);
        tick();
        rna = 5'd0;
        @(negedge clk);
        chk("lit_r0_read", qa_b, 32'd0);
        chk("lit_r9_again", qb_b, 32'hDEAD_BEEF);
        tick();

        // Bypass and port priority
        we0 = 1'b1; wn0 = 5'd7; d0 = 32'hAAAA_AAAA;
        we1 = 1'b1; wn1 = 5'd7; d1 = 32'h5555_5555;
        rna = 5'd7;
        @(negedge clk);
        chk("lit_bypass_prio", qa_b, 32'h5555_5555);
        chk("lit_nobypass_old", qa_n, 32'd0);
        tick();
        @(negedge clk);
        chk("lit_r7_after", qa_n, 32'h5555_5555);
        tick();

        // R0 protection
        we0 = 1'b1; wn0 = 5'd0; d0 = 32'hFFFF_FFFF;
        we1 = 1'b1; wn1 = 5'd0; d1 = 32'hFFFF_FFFF;
        iss_we = 1'b1; iss_wn = 5'd0; rna = 5'd0;
        @(negedge clk);
        chk("lit_r0_q_same", qa_b, 32'd0);
        tick();
        @(negedge clk);
        chk("lit_r0_q_after", qa_n, 32'd0);
        chk("lit_r0_p_after", {31'd0, pa_b}, 32'd0);
        tick();

        // Scoreboard set / clear / set-wins
        iss_we = 1'b1; iss_wn = 5'd12;
        tick();
        rna = 5'd12;
        @(negedge clk);
        chk("lit_pend_set", {31'd0, pa_b}, 32'd1);
        tick();
        tick();
        we1 = 1'b1; wn1 = 5'd12; d1 = 32'h42;
        @(negedge clk);
        chk("lit_clr_pa_byp", {31'd0, pa_b}, 32'd0);
        chk("lit_clr_qa_byp", qa_b, 32'h42);
        chk("lit_clr_pa_nob", {31'd0, pa_n}, 32'd1);
        tick();
        @(negedge clk);
        chk("lit_clr_pa_after", {31'd0, pa_n}, 32'd0);
        tick();
        iss_we = 1'b1; iss_wn = 5'd12;
        we1 = 1'b1; wn1 = 5'd12; d1 = 32'h43;
        tick();
        @(negedge clk);
        chk("lit_set_wins", {31'd0, pa_b}, 32'd1);
        chk("lit_set_wins_q", qa_n, 32'h43);
        tick();

        // Reset mid-operation
        iss_we = 1'b1; iss_wn = 5'd3;
        we0 = 1'b1; wn0 = 5'd3; d0 = 32'h77;
        dbg_rn = 5'd3;
        tick();
        rna = 5'd3;
        @(negedge clk);
        chk("lit_r3_pend", {31'd0, pa_b}, 32'd1);
        chk("lit_r3_val", qa_b, 32'h77);
        #2;
        clrn = 1'b0;
        model_reset();
        #1;
        chk("lit_rst_qa", qa_b, 32'd0);
        chk("lit_rst_pa", {31'd0, pa_b}, 32'd0);
        chk("lit_rst_dbg", dbg_b, 32'd0);
        tick();
        clrn = 1'b1;
        we0 = 1'b1; wn0 = 5'd3; d0 = 32'h99;
        tick();
        @(negedge clk);
        chk("lit_first_write", qa_n, 32'h99);
        tick();

        // Random traffic, addresses biased toward a few registers to provoke collisions
        for (int c = 0; c < 600; c++) begin
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            iss_we = 1'($urandom_range(0, 1));
            wn0 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wn1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            iss_wn = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            rna = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            rnb = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            dbg_rn = 5'($urandom_range(0, 7));
            d0 = $urandom;
            d1 = $urandom;
            tick();
        end
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
